// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter with a one-entry holding register.
// Bytes enter over a valid/ready handshake; a byte waiting in the holding
// register is loaded at the end of the current stop bit, so frames can run
// back-to-back with no idle gap. Line output and done pulse are registered.
module uart_byte_tx #(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned BAUD     = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       uart_tx,
   output logic       tx_busy,
   output logic       tx_done
);

   // Clocks per bit (integer truncation); must be at least 2.
   localparam int unsigned BIT_CNT = CLK_FREQ / BAUD;
   localparam int unsigned CNT_W   = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CNT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       hold_q;
   logic             hold_full_q;
   logic             line_q, line_d;
   logic             done_q, done_d;

   logic             accept;
   logic             load;
   logic             bit_end;
   logic [2:0]       idx_inc;

   assign accept   = tx_valid && tx_ready;
   assign bit_end  = (cnt_q == CNT_LAST);
   assign idx_inc  = idx_q + 3'd1;

   assign tx_ready = !hold_full_q;
   assign tx_busy  = (state_q != IDLE) || hold_full_q;
   assign uart_tx  = line_q;
   assign tx_done  = done_q;

   // Holding register: filled on accept, emptied when its byte moves to the shifter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else if (load) begin
         hold_full_q <= 1'b0;
      end else if (accept) begin
         hold_q      <= tx_data;
         hold_full_q <= 1'b1;
      end
   end

   // Frame state, bit timing, shifter and registered line/done outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         line_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         line_q  <= line_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic; the line value is computed one clock ahead so the pin is a flop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      line_d  = line_q;
      done_d  = 1'b0;
      load    = 1'b0;

      case (state_q)
         IDLE: begin
            line_d = 1'b1;
            cnt_d  = '0;
            if (hold_full_q) begin
               load = 1'b1;
            end
         end

         START: begin
            if (bit_end) begin
               state_d = DATA;
               cnt_d   = '0;
               idx_d   = '0;
               line_d  = shift_q[0];
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
         end

         DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (idx_q == 3'd7) begin
                  state_d = STOP;
                  line_d  = 1'b1;
               end else begin
                  idx_d  = idx_inc;
                  line_d = shift_q[idx_inc];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         STOP: begin
            if (bit_end) begin
               cnt_d  = '0;
               line_d = 1'b1;
               if (hold_full_q) begin
                  load = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            line_d  = 1'b1;
         end
      endcase

      // A load from IDLE or from the last stop clock starts a fresh frame.
      if (load) begin
         shift_d = hold_q;
         state_d = START;
         cnt_d   = '0;
         idx_d   = '0;
         line_d  = 1'b0;
      end

      // Done is registered: it is high in the cycle whose state is the last stop clock.
      done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
   end

endmodule
